geofence_sqrt_arbiter: RTL and testbench

Shared integer square-root resource for the geofence datapath. Arbitrates between up to 4 requesters, for example the edge-length path (dx²+dy²) and the Heron-area path (s(s-a), (s-b)(s-c)). Grants one request at a time and computes floor(sqrt) of a 20-bit radicand with a bit-serial 10-iteration engine. Returns the root, tagged with the requester index, over a valid/ready response handshake.

---
 rtl/geofence_sqrt_arbiter.sv | 162 ++++++++++++++++
 tb/tb_geofence_sqrt_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/geofence_sqrt_arbiter.sv
// Shared floor(sqrt) engine for the geofence datapath: arbitrates NUM_REQ requesters
// and runs a 10-step bit-serial root. Define SQRTARB_FIXED_PRIO_EN for fixed priority.
module geofence_sqrt_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int RAD_W   = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*RAD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_id,
  output logic [RAD_W/2-1:0]       rsp_root
);

  localparam int RW    = RAD_W / 2;
  localparam int CNT_W = $clog2(RW);

  typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_t;

  state_t             state_q, state_d;
  logic [RAD_W-1:0]   rad_q;
  logic [1:0]         id_q;
  logic [RW-1:0]      ans_q;
  logic [RW-1:0]      bit_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rsp_valid_q;
  logic [1:0]         rsp_id_q;
  logic [RW-1:0]      rsp_root_q;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [3:0]         req_pad;
  logic [RAD_W-1:0]   data_arr [4];
  logic [RW-1:0]      step_ans;
  logic               last_iter;

  // One restoring-root step: keep the trial bit if its square still fits.
  function automatic logic [RW-1:0] sqrt_step(input logic [RW-1:0]    ans,
                                              input logic [RW-1:0]    bitv,
                                              input logic [RAD_W-1:0] rad);
    logic [RW-1:0]    trial;
    logic [RAD_W-1:0] sq;
    trial = ans | bitv;
    sq    = RAD_W'(trial) * RAD_W'(trial);
    return (sq <= rad) ? trial : ans;
  endfunction

  assign req_pad = 4'(req);

  for (genvar g = 0; g < 4; g++) begin : g_data
    if (g < NUM_REQ) begin : g_used
      assign data_arr[g] = req_data[g*RAD_W +: RAD_W];
    end else begin : g_pad
      assign data_arr[g] = '0;
    end
  end

`ifdef SQRTARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_pad[2'(k)]) begin
        win_found = 1'b1;
        win_idx   = 2'(k);
      end
    end
  end
`else
  logic [1:0] rr_q;
  logic [2:0] cand;

  // Round-robin search starting at rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_q} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!win_found && req_pad[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end
`endif

  assign step_ans  = sqrt_step(ans_q, bit_q, rad_q);
  assign last_iter = (cnt_q == CNT_W'(RW - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found) state_d = COMPUTE;
      COMPUTE: if (last_iter) state_d = RESPOND;
      RESPOND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rad_q       <= '0;
      id_q        <= '0;
      ans_q       <= '0;
      bit_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_root_q  <= '0;
`ifndef SQRTARB_FIXED_PRIO_EN
      rr_q        <= '0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            rad_q <= data_arr[win_idx];
            id_q  <= win_idx;
            ans_q <= '0;
            bit_q <= RW'(1) << (RW - 1);
            cnt_q <= '0;
          end
        end
        COMPUTE: begin
          ans_q <= step_ans;
          bit_q <= bit_q >> 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            rsp_root_q  <= step_ans;
            rsp_id_q    <= id_q;
            rsp_valid_q <= 1'b1;
          end
        end
        RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
`ifndef SQRTARB_FIXED_PRIO_EN
            rr_q        <= (id_q == 2'(NUM_REQ - 1)) ? 2'd0 : id_q + 2'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Grants only from IDLE and never while reset is being applied.
  assign gnt       = (state_q == IDLE && win_found && !reset) ? NUM_REQ'(4'b0001 << win_idx) : '0;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_root  = rsp_root_q;

endmodule

// File: tb/tb_geofence_sqrt_arbiter.sv
// Scoreboard bench for geofence_sqrt_arbiter: a transaction-level model predicts grants,
// busy and tagged roots; a negedge monitor checks the DUT against it every cycle.
module tb_geofence_sqrt_arbiter;

  localparam int N = 2;
  localparam int W = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    gnt;
  logic            busy;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic [W/2-1:0]  rsp_root;

  geofence_sqrt_arbiter #(.NUM_REQ(N), .RAD_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_root(rsp_root)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int root;
    int due;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   m_free = 1'b1;
  bit   m_busy = 1'b0;
  int   m_rr = 0;
  int   last_id = 0;
  int   last_root = 0;
  logic [N-1:0] g_seen;

  function automatic int isqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef SQRTARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`endif
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and monitor.
  always @(negedge clk) begin
    int  w;
    int  exp_g;
    bit  granted;
    bit  hs;
    cyc++;
    if (reset) begin
      m_free = 1'b1; m_busy = 1'b0; m_rr = 0;
      last_id = 0; last_root = 0;
      q.delete();
    end else begin
      exp_g = 0; granted = 1'b0; hs = 1'b0; w = 0;
      if (m_free && req != '0) begin
        w = pick(req, m_rr);
        exp_g = 1 << w;
        granted = 1'b1;
      end
      check("gnt", int'(gnt), exp_g);
      check("busy", int'(busy), int'(m_busy));
      if (q.size() > 0 && cyc >= q[0].due) begin
        check("rsp_valid", int'(rsp_valid), 1);
        check("rsp_id", int'(rsp_id), q[0].id);
        check("rsp_root", int'(rsp_root), q[0].root);
        if (rsp_ready) begin
          last_id = q[0].id; last_root = q[0].root;
          m_rr = (q[0].id + 1) % N;
          void'(q.pop_front());
          hs = 1'b1;
        end
      end else begin
        check("rsp_valid_idle", int'(rsp_valid), 0);
        check("rsp_id_hold", int'(rsp_id), last_id);
        check("rsp_root_hold", int'(rsp_root), last_root);
      end
      if (granted) begin
        q.push_back('{id: w, root: isqrt(int'(req_data[w*W +: W])), due: cyc + 11});
        m_free = 1'b0; m_busy = 1'b1;
      end
      if (hs) begin
        m_free = 1'b1; m_busy = 1'b0;
      end
    end
  end

  task automatic step(input bit keep);
    @(negedge clk);
    g_seen = gnt;
    @(posedge clk);
    #1;
    if (!keep) req = req & ~g_seen;
  endtask

  function automatic logic [W-1:0] rnd_rad();
    int n;
    n = $urandom_range(1, 1023);
    case ($urandom_range(0, 7))
      0: return 20'd0;
      1: return 20'hFFFFF;
      2: return 20'd1046529;
      3: return 20'd1046528;
      4: return W'(n * n);
      5: return W'(n * n - 1);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic issue(input int i, input logic [W-1:0] v);
    int t;
    req_data[i*W +: W] = v;
    req[i] = 1'b1;
    t = 0;
    do begin
      step(1'b0);
      t++;
    end while (!g_seen[i] && t < 100);
    if (!g_seen[i]) check("grant_timeout", 0, 1);
  endtask

  initial begin
    logic [W-1:0] ext [5];
    ext[0] = 20'd99; ext[1] = 20'd0; ext[2] = 20'hFFFFF;
    ext[3] = 20'd1046529; ext[4] = 20'd1046528;
    reset = 1'b1; req = '0; req_data = '0; rsp_ready = 1'b0;
    repeat (3) step(1'b0);
    reset = 1'b0;

    // Single requests and extreme radicands.
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(0, ext[i]);
      repeat (14) step(1'b0);
    end

    // Contention with both requests held continuously.
    req_data[0 +: W] = 20'd144;
    req_data[W +: W] = 20'd400;
    req = 2'b11;
    repeat (60) step(1'b1);

    // Backpressure while requests stay asserted.
    rsp_ready = 1'b0;
    repeat (22) step(1'b1);
    rsp_ready = 1'b1;
    repeat (15) step(1'b1);
    req = '0;
    repeat (15) step(1'b0);

    // Randomized traffic with random backpressure and early request drops.
    for (int c = 0; c < 1500; c++) begin
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req_data[i*W +: W] = rnd_rad();
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 19) == 0) begin
          req[i] = 1'b0;
        end
      end
      step(1'b0);
    end

    // Reset in the middle of a computation, then a lone request from requester 1.
    req = '0; rsp_ready = 1'b1;
    repeat (20) step(1'b0);
    issue(0, 20'd12345);
    repeat (4) step(1'b0);
    reset = 1'b1;
    req = '0;
    step(1'b0);
    reset = 1'b0;
    repeat (15) step(1'b0);
    issue(1, 20'd2500);
    repeat (20) step(1'b0);

    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
